// File: rtl/transform_sequencer_pkg.sv
// Shared types and helpers for the FFT/NTT transform sequencer.
package transform_sequencer_pkg;

    localparam int K_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_SETTLE,
        ST_RUN,
        ST_WRAP,
        ST_FINISH
    } state_t;

    typedef enum logic [1:0] {
        N_SEL_8K      = 2'd0,
        N_SEL_16K     = 2'd1,
        N_SEL_32K     = 2'd2,
        N_SEL_ILLEGAL = 2'd3
    } n_sel_t;

    // Twiddle/modulus ROM select: direction bit above the limb index.
    function automatic logic [K_W:0] pack_constants_sel(input logic is_dif,
                                                        input logic [K_W-1:0] k);
        return {is_dif, k};
    endfunction

endpackage

// File: rtl/transform_sequencer_if.sv
// Command, loader handshake and transform-unit control bundle for the sequencer.
interface transform_sequencer_if #(
    parameter int K_WIDTH = transform_sequencer_pkg::K_W
);
    logic               start;
    logic               cmd_is_fft;
    logic               cmd_is_dif;
    logic [1:0]         cmd_n_sel;
    logic [K_WIDTH-1:0] cmd_first_k;
    logic [K_WIDTH-1:0] cmd_num_limbs;
    logic               limb_ready;
    logic               tf_done;

    logic               busy;
    logic               done;
    logic               error;
    logic               limb_req;
    logic               limb_done;
    logic [K_WIDTH-1:0] limb_idx;
    logic               tf_rst;
    logic               tf_is_fft;
    logic               tf_is_dif;
    logic [K_WIDTH-1:0] tf_current_k;
    logic [1:0]         tf_current_n;
    logic [K_WIDTH:0]   tf_constants_sel;

    modport slave (
        input  start, cmd_is_fft, cmd_is_dif, cmd_n_sel, cmd_first_k, cmd_num_limbs,
               limb_ready, tf_done,
        output busy, done, error, limb_req, limb_done, limb_idx,
               tf_rst, tf_is_fft, tf_is_dif, tf_current_k, tf_current_n, tf_constants_sel
    );

    modport master (
        output start, cmd_is_fft, cmd_is_dif, cmd_n_sel, cmd_first_k, cmd_num_limbs,
               limb_ready, tf_done,
        input  busy, done, error, limb_req, limb_done, limb_idx,
               tf_rst, tf_is_fft, tf_is_dif, tf_current_k, tf_current_n, tf_constants_sel
    );

endinterface

// File: rtl/transform_sequencer_seq_watchdog.sv
// Loadable down-counter; expired is high while the count sits at zero.
module transform_sequencer_seq_watchdog #(
    parameter int WIDTH = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             expired
);
    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/transform_sequencer.sv
// Sequences one FFT or multi-limb NTT command through loader handshake, settle and run.
//
// state  | meaning
// IDLE   | no command; transform held in reset
// REQ    | asking the loader for limb limb_idx
// SETTLE | data loaded; hold tf_rst while mode/n/k propagate
// RUN    | transform running; watchdog armed
// WRAP   | limb written back; advance or finish
// FINISH | pulse done, drop busy
module transform_sequencer
    import transform_sequencer_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 2**20,
    parameter int K_WIDTH        = K_W
) (
    input  logic clk,
    input  logic rst,
    transform_sequencer_if.slave bus
);
    localparam int CNT_MAX = (TIMEOUT_CYCLES > SETTLE_CYCLES) ? TIMEOUT_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LOAD  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t             state;
    logic               run_first;
    logic [K_WIDTH-1:0] limbs_left;

    logic               busy_q, done_q, error_q, limb_req_q, limb_done_q;
    logic [K_WIDTH-1:0] limb_idx_q;
    logic               tf_rst_q, tf_is_fft_q, tf_is_dif_q;
    logic [1:0]         tf_current_n_q;
    logic [K_WIDTH:0]   tf_constants_sel_q;

    logic               cmd_legal;
    logic               wd_load;
    logic [CNT_W-1:0]   wd_value;
    logic               wd_expired;

    assign cmd_legal = (bus.cmd_n_sel != N_SEL_ILLEGAL) &&
                       (bus.cmd_is_fft || (bus.cmd_num_limbs != '0));

    // One counter serves both phases: settle length in REQ->SETTLE, timeout on SETTLE->RUN.
    always_comb begin
        wd_load  = 1'b0;
        wd_value = TIMEOUT_LOAD;
        if (state == ST_REQ) begin
            wd_load  = bus.limb_ready;
            wd_value = SETTLE_LOAD;
        end else if (state == ST_SETTLE) begin
            wd_load  = wd_expired;
        end
    end

    transform_sequencer_seq_watchdog #(.WIDTH(CNT_W)) u_watchdog (
        .clk        (clk),
        .rst        (rst),
        .load       (wd_load),
        .load_value (wd_value),
        .expired    (wd_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= ST_IDLE;
            run_first          <= 1'b0;
            limbs_left         <= '0;
            busy_q             <= 1'b0;
            done_q             <= 1'b0;
            error_q            <= 1'b0;
            limb_req_q         <= 1'b0;
            limb_done_q        <= 1'b0;
            limb_idx_q         <= '0;
            tf_rst_q           <= 1'b1;
            tf_is_fft_q        <= 1'b0;
            tf_is_dif_q        <= 1'b0;
            tf_current_n_q     <= '0;
            tf_constants_sel_q <= '0;
        end else begin
            done_q      <= 1'b0;
            limb_done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (cmd_legal) begin
                            state              <= ST_REQ;
                            busy_q             <= 1'b1;
                            error_q            <= 1'b0;
                            limb_req_q         <= 1'b1;
                            tf_is_fft_q        <= bus.cmd_is_fft;
                            tf_is_dif_q        <= bus.cmd_is_dif;
                            tf_current_n_q     <= bus.cmd_n_sel;
                            limb_idx_q         <= bus.cmd_first_k;
                            limbs_left         <= bus.cmd_is_fft ? K_WIDTH'(1) : bus.cmd_num_limbs;
                            tf_constants_sel_q <= pack_constants_sel(bus.cmd_is_dif, bus.cmd_first_k);
                        end else begin
                            error_q <= 1'b1;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_REQ: begin
                    if (bus.limb_ready) begin
                        limb_req_q <= 1'b0;
                        state      <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (wd_expired) begin
                        tf_rst_q  <= 1'b0;
                        run_first <= 1'b1;
                        state     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    run_first <= 1'b0;
                    // tf_done may still be high from the previous limb on the first RUN cycle.
                    if (bus.tf_done && !run_first) begin
                        tf_rst_q    <= 1'b1;
                        limb_done_q <= 1'b1;
                        state       <= ST_WRAP;
                    end else if (wd_expired) begin
                        tf_rst_q <= 1'b1;
                        error_q  <= 1'b1;
                        state    <= ST_FINISH;
                    end
                end
                ST_WRAP: begin
                    if (limbs_left > K_WIDTH'(1)) begin
                        limbs_left         <= limbs_left - K_WIDTH'(1);
                        limb_idx_q         <= limb_idx_q + K_WIDTH'(1);
                        tf_constants_sel_q <= pack_constants_sel(tf_is_dif_q, limb_idx_q + K_WIDTH'(1));
                        limb_req_q         <= 1'b1;
                        state              <= ST_REQ;
                    end else begin
                        state <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.error            = error_q;
    assign bus.limb_req         = limb_req_q;
    assign bus.limb_done        = limb_done_q;
    assign bus.limb_idx         = limb_idx_q;
    assign bus.tf_rst           = tf_rst_q;
    assign bus.tf_is_fft        = tf_is_fft_q;
    assign bus.tf_is_dif        = tf_is_dif_q;
    assign bus.tf_current_k     = limb_idx_q;
    assign bus.tf_current_n     = tf_current_n_q;
    assign bus.tf_constants_sel = tf_constants_sel_q;

endmodule

// File: tb/tb_transform_sequencer.sv
// Directed bench for transform_sequencer: command table plus hand-built corner sequences.
module tb_transform_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    transform_sequencer_if #(.K_WIDTH(4)) b ();
    transform_sequencer_if #(.K_WIDTH(4)) bt ();

    transform_sequencer #(.SETTLE_CYCLES(4), .TIMEOUT_CYCLES(1 << 20), .K_WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (b)
    );

    transform_sequencer #(.SETTLE_CYCLES(4), .TIMEOUT_CYCLES(64), .K_WIDTH(4)) dut_to (
        .clk (clk),
        .rst (rst),
        .bus (bt)
    );

    typedef struct packed {
        logic       is_fft;
        logic       is_dif;
        logic [1:0] n_sel;
        logic [3:0] first_k;
        logic [3:0] num_limbs;
        logic [7:0] done_delay;
        logic       exp_error;
        logic [4:0] exp_limbs;
        logic [3:0] exp_idx0;
        logic [4:0] exp_sel0;
    } vec_t;

    localparam logic [22:0] RESET_SNAP = 23'b00000_100_00_0000_0000_00000;
    localparam int SETTLE_GAP = 5;

    int n_pass = 0;
    int n_total = 0;

    int         n_ld, n_done, settle_bad;
    logic       rst_fell, timed_out;
    logic [3:0] got_idx [16];
    logic [3:0] got_k   [16];
    logic [4:0] got_sel [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [22:0] snap();
        return {b.busy, b.done, b.error, b.limb_req, b.limb_done,
                b.tf_rst, b.tf_is_fft, b.tf_is_dif, b.tf_current_n,
                b.limb_idx, b.tf_current_k, b.tf_constants_sel};
    endfunction

    task automatic drive_cmd(input logic is_fft, input logic is_dif, input logic [1:0] n_sel,
                             input logic [3:0] first_k, input logic [3:0] num_limbs);
        b.cmd_is_fft    = is_fft;
        b.cmd_is_dif    = is_dif;
        b.cmd_n_sel     = n_sel;
        b.cmd_first_k   = first_k;
        b.cmd_num_limbs = num_limbs;
        b.start         = 1'b1;
        @(negedge clk);
        b.start = 1'b0;
    endtask

    // Loader answers 5 cycles after limb_req; transform finishes done_delay cycles after tf_rst falls.
    task automatic run_cmd(input vec_t v);
        int   cyc, req_wait, run_cnt, ready_at, extra;
        logic prev_rst;
        n_ld = 0; n_done = 0; settle_bad = 0; rst_fell = 1'b0;
        req_wait = 0; run_cnt = 0; ready_at = -100; cyc = 0; prev_rst = 1'b1;
        drive_cmd(v.is_fft, v.is_dif, v.n_sel, v.first_k, v.num_limbs);
        while (n_done == 0 && cyc < 3000) begin
            if (b.limb_done && n_ld < 16) begin
                got_idx[n_ld] = b.limb_idx;
                got_k[n_ld]   = b.tf_current_k;
                got_sel[n_ld] = b.tf_constants_sel;
                n_ld++;
            end
            if (b.done) n_done++;
            if (!b.tf_rst && prev_rst) begin
                rst_fell = 1'b1;
                if (cyc - ready_at != SETTLE_GAP) settle_bad++;
            end
            b.limb_ready = 1'b0;
            if (b.limb_req) begin
                req_wait++;
                if (req_wait >= 6) begin
                    b.limb_ready = 1'b1;
                    ready_at = cyc;
                end
            end else begin
                req_wait = 0;
            end
            if (!b.tf_rst) run_cnt++;
            else run_cnt = 0;
            b.tf_done = (run_cnt >= int'(v.done_delay));
            prev_rst = b.tf_rst;
            cyc++;
            if (n_done == 0) @(negedge clk);
        end
        timed_out = (n_done == 0);
        b.tf_done = 1'b0;
        b.limb_ready = 1'b0;
        extra = 0;
        repeat (3) begin
            @(negedge clk);
            if (b.done) extra++;
        end
        n_done += extra;
    endtask

    task automatic serve_until_run(output logic ok);
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (!b.tf_rst) begin
                ok = 1'b1;
                break;
            end
            b.limb_ready = b.limb_req;
            @(negedge clk);
        end
        b.limb_ready = 1'b0;
    endtask

    task automatic wait_done(output logic seen);
        seen = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (b.done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    vec_t vecs [7];

    initial begin
        #500000;
        $display("FAIL global time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_total + 1);
        $fatal(1);
    end

    initial begin
        logic       ok, seen;
        logic [3:0] eidx;
        int         cnt, ld;

        vecs[0] = '{1'b0, 1'b0, 2'd2, 4'd2,  4'd3, 8'd100, 1'b0, 5'd3, 4'd2,  5'h02};
        vecs[1] = '{1'b0, 1'b0, 2'd3, 4'd1,  4'd2, 8'd10,  1'b1, 5'd0, 4'd0,  5'h00};
        vecs[2] = '{1'b1, 1'b1, 2'd1, 4'd5,  4'd9, 8'd20,  1'b0, 5'd1, 4'd5,  5'h15};
        vecs[3] = '{1'b0, 1'b1, 2'd0, 4'd4,  4'd0, 8'd10,  1'b1, 5'd0, 4'd0,  5'h00};
        vecs[4] = '{1'b0, 1'b1, 2'd0, 4'd15, 4'd2, 8'd10,  1'b0, 5'd2, 4'd15, 5'h1F};
        vecs[5] = '{1'b1, 1'b0, 2'd3, 4'd8,  4'd1, 8'd10,  1'b1, 5'd0, 4'd0,  5'h00};
        vecs[6] = '{1'b0, 1'b0, 2'd1, 4'd7,  4'd1, 8'd3,   1'b0, 5'd1, 4'd7,  5'h07};

        {b.start, b.cmd_is_fft, b.cmd_is_dif, b.limb_ready, b.tf_done} = '0;
        b.cmd_n_sel = '0; b.cmd_first_k = '0; b.cmd_num_limbs = '0;
        {bt.start, bt.cmd_is_fft, bt.cmd_is_dif, bt.limb_ready, bt.tf_done} = '0;
        bt.cmd_n_sel = '0; bt.cmd_first_k = '0; bt.cmd_num_limbs = '0;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset values", 32'(snap()), 32'(RESET_SNAP));
        rst = 1'b0;
        @(negedge clk);
        check("idle after reset", 32'(snap()), 32'(RESET_SNAP));

        for (int i = 0; i < 7; i++) begin
            run_cmd(vecs[i]);
            check($sformatf("v%0d done pulses", i), 32'(n_done), 32'd1);
            check($sformatf("v%0d error", i), 32'(b.error), 32'(vecs[i].exp_error));
            check($sformatf("v%0d busy", i), 32'(b.busy), 32'd0);
            check($sformatf("v%0d limb_done count", i), 32'(n_ld), 32'(vecs[i].exp_limbs));
            check($sformatf("v%0d tf_rst fell", i), 32'(rst_fell), 32'(vecs[i].exp_limbs != 0));
            for (int k = 0; k < n_ld && k < int'(vecs[i].exp_limbs); k++) begin
                eidx = vecs[i].exp_idx0 + 4'(k);
                check($sformatf("v%0d limb%0d idx", i, k), 32'(got_idx[k]), 32'(eidx));
                check($sformatf("v%0d limb%0d current_k", i, k), 32'(got_k[k]), 32'(eidx));
                check($sformatf("v%0d limb%0d constants_sel", i, k), 32'(got_sel[k]),
                      32'({vecs[i].exp_sel0[4], eidx}));
            end
            if (vecs[i].exp_limbs != 0) begin
                check($sformatf("v%0d settle", i), 32'(settle_bad), 32'd0);
                check($sformatf("v%0d tf_current_n", i), 32'(b.tf_current_n), 32'(vecs[i].n_sel));
                check($sformatf("v%0d tf_is_fft", i), 32'(b.tf_is_fft), 32'(vecs[i].is_fft));
            end
        end

        // Stale tf_done at RUN entry.
        b.tf_done = 1'b1;
        drive_cmd(1'b0, 1'b0, 2'd0, 4'd1, 4'd1);
        serve_until_run(ok);
        check("stale reached run", 32'(ok), 32'd1);
        @(negedge clk);
        check("stale first cycle limb_done", 32'(b.limb_done), 32'd0);
        check("stale first cycle tf_rst", 32'(b.tf_rst), 32'd0);
        @(negedge clk);
        check("stale second cycle limb_done", 32'(b.limb_done), 32'd1);
        b.tf_done = 1'b0;
        wait_done(seen);
        check("stale done", 32'(seen), 32'd1);
        @(negedge clk);

        // Start while busy, then reset in RUN of limb 1.
        drive_cmd(1'b0, 1'b0, 2'd1, 4'd3, 4'd2);
        drive_cmd(1'b1, 1'b1, 2'd0, 4'd9, 4'd1);
        @(negedge clk);
        check("busy start limb_idx", 32'(b.limb_idx), 32'd3);
        check("busy start constants_sel", 32'(b.tf_constants_sel), 32'h03);
        check("busy start tf_current_n", 32'(b.tf_current_n), 32'd1);
        check("busy start tf_is_fft", 32'(b.tf_is_fft), 32'd0);
        check("busy start busy", 32'(b.busy), 32'd1);
        serve_until_run(ok);
        check("limb0 reached run", 32'(ok), 32'd1);
        repeat (3) @(negedge clk);
        b.tf_done = 1'b1;
        @(negedge clk);
        check("limb0 limb_done", 32'({b.limb_done, b.limb_idx}), 32'({1'b1, 4'd3}));
        b.tf_done = 1'b0;
        serve_until_run(ok);
        check("limb1 reached run", 32'(ok), 32'd1);
        check("limb1 idx", 32'(b.limb_idx), 32'd4);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid-run reset values", 32'(snap()), 32'(RESET_SNAP));
        rst = 1'b0;
        @(negedge clk);
        check("after mid-run reset", 32'(snap()), 32'(RESET_SNAP));

        // Watchdog timeout on the short-timeout instance.
        bt.cmd_is_fft = 1'b0; bt.cmd_is_dif = 1'b0; bt.cmd_n_sel = 2'd2;
        bt.cmd_first_k = 4'd6; bt.cmd_num_limbs = 4'd1; bt.start = 1'b1;
        @(negedge clk);
        bt.start = 1'b0;
        ok = 1'b0; ld = 0;
        for (int c = 0; c < 200; c++) begin
            if (!bt.tf_rst) begin
                ok = 1'b1;
                break;
            end
            bt.limb_ready = bt.limb_req;
            @(negedge clk);
        end
        bt.limb_ready = 1'b0;
        check("timeout reached run", 32'(ok), 32'd1);
        cnt = 0;
        while (!bt.error && cnt < 200) begin
            if (bt.limb_done) ld++;
            cnt++;
            @(negedge clk);
        end
        check("timeout latency", 32'(cnt), 32'd64);
        check("timeout tf_rst", 32'(bt.tf_rst), 32'd1);
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (bt.limb_done) ld++;
            if (bt.done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("timeout done", 32'(seen), 32'd1);
        check("timeout no limb_done", 32'(ld), 32'd0);
        @(negedge clk);
        check("timeout error sticky", 32'({bt.error, bt.busy}), 32'b10);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
